// File: rtl/ipv6_header_tx_arbiter.sv
// Round-robin arbiter that captures one 320-bit IPv6 header from N requesters
// and serialises it MSB-first as ten 32-bit words on a valid/ready stream.
module ipv6_header_tx_arbiter #(
    parameter int N     = 4,
    parameter int SRC_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_valid,
    input  logic [N*320-1:0]   req_header,
    output logic [N-1:0]       req_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic               out_last,
    output logic [SRC_W-1:0]   out_src,
    output logic               busy,
    output logic [15:0]        hdr_cnt
);

    localparam logic       STATE_IDLE = 1'b0;
    localparam logic       STATE_SEND = 1'b1;
    localparam logic [3:0] LAST_WORD  = 4'd9;

    logic             state_q, state_d;
    logic [319:0]     hdr_q, hdr_d;
    logic [3:0]       idx_q, idx_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic [15:0]      hdr_cnt_q, hdr_cnt_d;

    logic [319:0]     hdr_arr [N];
    logic [31:0]      word_arr [10];

    logic             win_found;
    logic [SRC_W-1:0] win_idx;
    logic [SRC_W-1:0] cand;
    logic             last_hs;
    logic             grant_open;
    logic             grant_fire;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_req
            assign hdr_arr[gi]   = req_header[gi*320 +: 320];
            assign req_ready[gi] = grant_fire && (win_idx == SRC_W'(gi));
        end
        for (genvar gi = 0; gi < 10; gi++) begin : g_word
            assign word_arr[gi] = hdr_q[319-32*gi -: 32];
        end
    endgenerate

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = SRC_W'((int'(ptr_q) + k) % N);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign last_hs    = (state_q == STATE_SEND) && out_ready && (idx_q == LAST_WORD);
    assign grant_open = (state_q == STATE_IDLE) || last_hs;
    assign grant_fire = grant_open && win_found && !rst;

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        idx_d     = idx_q;
        src_d     = src_q;
        ptr_d     = ptr_q;
        hdr_cnt_d = hdr_cnt_q;

        if ((state_q == STATE_SEND) && out_ready) begin
            idx_d = (idx_q == LAST_WORD) ? 4'd0 : idx_q + 4'd1;
        end
        if (last_hs) begin
            state_d   = STATE_IDLE;
            hdr_cnt_d = hdr_cnt_q + 16'd1;
        end
        // A new grant on the last handshake overrides the return to idle.
        if (grant_fire) begin
            state_d = STATE_SEND;
            hdr_d   = hdr_arr[win_idx];
            src_d   = win_idx;
            ptr_d   = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STATE_IDLE;
            hdr_q     <= '0;
            idx_q     <= '0;
            src_q     <= '0;
            ptr_q     <= SRC_W'(N - 1);
            hdr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            idx_q     <= idx_d;
            src_q     <= src_d;
            ptr_q     <= ptr_d;
            hdr_cnt_q <= hdr_cnt_d;
        end
    end

    assign out_valid = (state_q == STATE_SEND);
    assign busy      = (state_q == STATE_SEND);
    assign out_last  = (state_q == STATE_SEND) && (idx_q == LAST_WORD);
    assign out_data  = word_arr[idx_q];
    assign out_src   = src_q;
    assign hdr_cnt   = hdr_cnt_q;

endmodule

// File: tb/tb_ipv6_header_tx_arbiter.sv
// Directed bench for ipv6_header_tx_arbiter: a transaction-level model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_ipv6_header_tx_arbiter;

    localparam int N     = 4;
    localparam int SRC_W = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N*320-1:0]   req_header;
    logic [N-1:0]       req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic               out_last;
    logic [SRC_W-1:0]   out_src;
    logic               busy;
    logic [15:0]        hdr_cnt;

    ipv6_header_tx_arbiter #(.N(N), .SRC_W(SRC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_header (req_header),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_src    (out_src),
        .busy       (busy),
        .hdr_cnt    (hdr_cnt)
    );

    always #5 clk = ~clk;

    logic [319:0] hdr_in [N];
    logic [N-1:0] hold;
    int           seq [N];
    logic         preload_en;

    always_comb begin
        req_header = '0;
        for (int i = 0; i < N; i++) req_header[i*320 +: 320] = hdr_in[i];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [319:0] make_hdr(input int i, input int s);
        return {4'h6, 8'(i*16 + s), 20'(s*4099 + i), 16'(40 + s), 8'h11, 8'h40,
                32'h20010db8, 32'(i), 32'(s), 32'hA0000000 + 32'(i*7),
                32'hfe800000, 32'(s*3), 32'hC0DE0000 ^ 32'(i), 32'(i + s)};
    endfunction

    function automatic int pick(input int ptr, input logic [N-1:0] v);
        for (int s = 1; s <= N; s++) begin
            if (v[(ptr + s) % N]) return (ptr + s) % N;
        end
        return -1;
    endfunction

    // Model state: which header is held, how many of its words have gone out.
    logic         m_valid = 1'b0;
    logic         m_busy  = 1'b0;
    int           m_k     = 0;
    int           m_src   = 0;
    int           m_ptr   = N - 1;
    logic [15:0]  m_cnt   = '0;
    logic [31:0]  m_words [10];
    logic [319:0] m_tmp;

    logic         prev_stall = 1'b0;
    logic [31:0]  prev_data;
    logic         prev_last;
    logic [SRC_W-1:0] prev_src;

    logic [N-1:0] ack_seen = '0;
    int           gr_q [$];
    logic [31:0]  acc_data [$];
    logic         acc_last [$];
    int           vcycles = 0;

    logic [N-1:0] exp_rdy;
    int           m_w;
    logic         m_opp;
    logic         m_lasths;

    always @(negedge clk) begin
        if (preload_en) m_cnt = 16'hFFFF;
        m_w      = pick(m_ptr, req_valid);
        m_lasths = m_busy && out_ready && (m_k == 9);
        m_opp    = !m_busy || m_lasths;
        exp_rdy  = '0;
        if (!rst && m_opp && m_w >= 0) exp_rdy[m_w] = 1'b1;

        if (m_valid) begin
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(m_busy));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("out_last", 64'(out_last), 64'(m_busy && m_k == 9));
            chk("out_src", 64'(out_src), 64'(m_src));
            chk("hdr_cnt", 64'(hdr_cnt), 64'(m_cnt));
            if (m_busy) chk("out_data", 64'(out_data), 64'(m_words[m_k]));
            if (prev_stall) begin
                chk("stall_data", 64'(out_data), 64'(prev_data));
                chk("stall_last", 64'(out_last), 64'(prev_last));
                chk("stall_src", 64'(out_src), 64'(prev_src));
            end
        end

        prev_stall = out_valid && !out_ready && !rst;
        prev_data  = out_data;
        prev_last  = out_last;
        prev_src   = out_src;
        ack_seen   = req_ready;
        for (int i = 0; i < N; i++) if (req_ready[i]) gr_q.push_back(i);
        if (out_valid) vcycles++;
        if (out_valid && out_ready) begin
            acc_data.push_back(out_data);
            acc_last.push_back(out_last);
            if (out_last)
                $display("[%0t] header done src=%0d last_word=%h hdr_cnt_before=%0d",
                         $time, out_src, out_data, hdr_cnt);
        end

        if (rst) begin
            m_busy  = 1'b0;
            m_k     = 0;
            m_src   = 0;
            m_ptr   = N - 1;
            m_cnt   = '0;
            m_valid = 1'b1;
        end else begin
            if (m_lasths) m_cnt = m_cnt + 16'd1;
            if (m_opp && m_w >= 0) begin
                m_tmp = hdr_in[m_w];
                for (int j = 0; j < 10; j++) m_words[j] = m_tmp[319-32*j -: 32];
                m_busy = 1'b1;
                m_k    = 0;
                m_src  = m_w;
                m_ptr  = m_w;
            end else if (m_lasths) begin
                m_busy = 1'b0;
                m_k    = 0;
            end else if (m_busy && out_ready) begin
                m_k++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack_seen[i]) begin
                seq[i]++;
                hdr_in[i]    = make_hdr(i, seq[i]);
                req_valid[i] = hold[i];
            end
        end
    endtask

    task automatic clear_logs();
        gr_q.delete();
        acc_data.delete();
        acc_last.delete();
        vcycles = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [31:0] t1_exp [10];
    int          rr_exp [5];
    int          skip_exp [4];
    logic [31:0] exp_w0;

    initial begin
        t1_exp   = '{32'h60012345, 32'h00401140, 32'h20010000, 32'h0, 32'h0,
                     32'h1, 32'h20010000, 32'h0, 32'h0, 32'h2};
        rr_exp   = '{0, 1, 2, 3, 0};
        skip_exp = '{1, 3, 0, 1};
        rst        = 1'b1;
        req_valid  = '0;
        out_ready  = 1'b1;
        hold       = '0;
        preload_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            seq[i]    = 0;
            hdr_in[i] = make_hdr(i, 0);
        end

        // Reset state and single header
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hdr_cnt", 64'(hdr_cnt), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        clear_logs();
        hdr_in[0] = {32'h60012345, 32'h00401140, 32'h20010000, 32'h0, 32'h0,
                     32'h1, 32'h20010000, 32'h0, 32'h0, 32'h2};
        req_valid = 4'b0001;
        #1;
        chk("t1_grant_same_cycle", 64'(req_ready), 64'b0001);
        repeat (11) step();
        chk("t1_word_count", 64'(acc_data.size()), 64'd10);
        for (int k = 0; k < 10 && k < acc_data.size(); k++)
            chk($sformatf("t1_word%0d", k), 64'(acc_data[k]), 64'(t1_exp[k]));
        if (acc_last.size() == 10) chk("t1_last_at_word9", 64'(acc_last[9]), 64'd1);
        chk("t1_hdr_cnt", 64'(hdr_cnt), 64'd1);
        chk("t1_busy_after", 64'(busy), 64'd0);

        // Round-robin fairness with every requester always pending
        do_reset();
        clear_logs();
        hold      = 4'hF;
        req_valid = 4'hF;
        repeat (41) step();
        chk("rr_grant_count", 64'(gr_q.size()), 64'd5);
        for (int k = 0; k < 5 && k < gr_q.size(); k++)
            chk($sformatf("rr_grant%0d", k), 64'(gr_q[k]), 64'(rr_exp[k]));
        chk("rr_valid_cycles", 64'(vcycles), 64'd40);
        chk("rr_hdr_cnt", 64'(hdr_cnt), 64'd4);
        hold      = '0;
        req_valid = '0;
        repeat (12) step();

        // Backpressure with other requesters waiting
        do_reset();
        clear_logs();
        req_valid = 4'b0001;
        step();
        req_valid = 4'b1110;
        for (int c = 0; c < 60; c++) begin
            out_ready = (c % 3 == 0);
            step();
            if (acc_last.size() > 0 && acc_last[acc_last.size()-1]) break;
        end
        chk("bp_words", 64'(acc_data.size()), 64'd10);
        chk("bp_grants_before_last", 64'(gr_q.size()), 64'd2);
        if (gr_q.size() >= 2) chk("bp_second_grant", 64'(gr_q[1]), 64'd1);
        out_ready = 1'b1;
        repeat (34) step();
        chk("bp_total_grants", 64'(gr_q.size()), 64'd4);
        chk("bp_hdr_cnt", 64'(hdr_cnt), 64'd4);

        // Pointer skip: last winner 1, then 3 and 0 pending, 1 re-raised later
        do_reset();
        clear_logs();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1001;
        repeat (15) step();
        req_valid[1] = 1'b1;
        repeat (30) step();
        chk("skip_grant_count", 64'(gr_q.size()), 64'd4);
        for (int k = 0; k < 4 && k < gr_q.size(); k++)
            chk($sformatf("skip_grant%0d", k), 64'(gr_q[k]), 64'(skip_exp[k]));

        // Reset in the middle of a header
        clear_logs();
        req_valid = 4'b0001;
        step();
        repeat (5) step();
        chk("mid_words_before_rst", 64'(acc_data.size()), 64'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_hdr_cnt", 64'(hdr_cnt), 64'd0);
        clear_logs();
        exp_w0    = hdr_in[0][319:288];
        req_valid = 4'b1001;
        repeat (25) step();
        chk("mid_grant_count", 64'(gr_q.size()), 64'd2);
        if (gr_q.size() >= 2) begin
            chk("mid_grant0", 64'(gr_q[0]), 64'd0);
            chk("mid_grant1", 64'(gr_q[1]), 64'd3);
        end
        if (acc_data.size() > 0) chk("mid_first_word", 64'(acc_data[0]), 64'(exp_w0));
        chk("mid_words_after", 64'(acc_data.size()), 64'd20);

        // Counter wrap
        clear_logs();
        force dut.hdr_cnt_q = 16'hFFFF;
        preload_en = 1'b1;
        step();
        release dut.hdr_cnt_q;
        preload_en = 1'b0;
        req_valid  = 4'b0010;
        repeat (12) step();
        chk("wrap_hdr_cnt", 64'(hdr_cnt), 64'd0);
        chk("wrap_grant_count", 64'(gr_q.size()), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
